// File: rtl/mc_controller_if.sv
// Control interface between the multicycle MIPS datapath and its main control FSM.
// master: the controller; slave: the datapath side.
interface mc_controller_if #(
    parameter int unsigned STATE_W = 4
);
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;
    logic [14:0]        control_bus;
    logic [STATE_W-1:0] state;
    logic               retire;

    modport master (
        input  op, funct, zero,
        output control_bus, state, retire
    );

    modport slave (
        output op, funct, zero,
        input  control_bus, state, retire
    );
endinterface

// File: rtl/mc_controller.sv
// Main control FSM for the multicycle MIPS core; drives the packed datapath control_bus.
// Optional feature: define MC_CTRL_BNE_EN to add bne (op 000101) through the BRANCH state.
module mc_controller #(
    parameter int unsigned STATE_W = 4
) (
    input logic            clk,
    input logic            reset,
    mc_controller_if.master bus
);

    typedef enum logic [STATE_W-1:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
        StExecute, StAluWb, StBranch, StAddiExec, StAddiWb, StJump
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBne   = 6'b000101;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;

    state_e state_q, state_d;

    logic       iord, mem_write, ir_write, pc_en, alu_src_a, reg_write, reg_dst, mem_to_reg;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_control;
    logic       retire_c;
    logic       branch_taken;

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

`ifdef MC_CTRL_BNE_EN
    logic is_bne_q;

    // Branch flavour is captured in DECODE so BRANCH does not depend on op.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_bne_q <= 1'b0;
        end else if (state_q == StDecode) begin
            is_bne_q <= (bus.op == OpBne);
        end
    end

    assign branch_taken = is_bne_q ? ~bus.zero : bus.zero;
`else
    assign branch_taken = bus.zero;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = StFetch;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_en       = 1'b0;
        alu_src_a   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        pc_src      = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        retire_c    = 1'b0;
        case (state_q)
            StFetch: begin
                ir_write    = 1'b1;
                pc_en       = 1'b1;
                alu_src_b   = 2'b01;
                alu_control = AluAdd;
                state_d     = StDecode;
            end
            StDecode: begin
                alu_src_b   = 2'b11;
                alu_control = AluAdd;
                case (bus.op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExecute;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiExec;
                    OpJ:        state_d = StJump;
`ifdef MC_CTRL_BNE_EN
                    OpBne:      state_d = StBranch;
`endif
                    default:    state_d = StFetch;
                endcase
            end
            StMemAdr: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = AluAdd;
                state_d     = (bus.op == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                iord    = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire_c   = 1'b1;
            end
            StMemWr: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                retire_c  = 1'b1;
            end
            StExecute: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu(bus.funct);
                state_d     = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire_c  = 1'b1;
            end
            StBranch: begin
                alu_src_a   = 1'b1;
                alu_control = AluSub;
                pc_src      = 2'b01;
                pc_en       = branch_taken;
                retire_c    = 1'b1;
            end
            StAddiExec: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = AluAdd;
                state_d     = StAddiWb;
            end
            StAddiWb: begin
                reg_write = 1'b1;
                retire_c  = 1'b1;
            end
            StJump: begin
                pc_src   = 2'b10;
                pc_en    = 1'b1;
                retire_c = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

    // Reset forces all strobes low so an abandoned instruction never writes.
    assign bus.control_bus = reset ? 15'd0 :
        {iord, mem_write, ir_write, pc_en, alu_src_a, reg_write, reg_dst, mem_to_reg,
         pc_src, alu_src_b, alu_control};
    assign bus.retire = reset ? 1'b0 : retire_c;
    assign bus.state  = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected state/control_bus/retire are queued
// when an instruction is issued and compared as the FSM steps through it.
module tb_mc_controller;

    localparam logic [3:0] StFetch = 4'd0, StDecode = 4'd1, StMemAdr = 4'd2, StMemRd = 4'd3;
    localparam logic [3:0] StMemWb = 4'd4, StMemWr = 4'd5, StExecute = 4'd6, StAluWb = 4'd7;
    localparam logic [3:0] StBranch = 4'd8, StAddiExec = 4'd9, StAddiWb = 4'd10, StJump = 4'd11;

    typedef struct packed {
        logic [3:0]  state;
        logic [14:0] bus;
        logic        retire;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    mc_controller_if #(.STATE_W(4)) dut_if ();

    mc_controller #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input logic [3:0] s, input logic [14:0] b, input logic r);
        exp_t e;
        e.state  = s;
        e.bus    = b;
        e.retire = r;
        sb.push_back(e);
    endtask

    task automatic cycle_check(input string tag);
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            check({tag, "_underflow"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_state"}, 32'(dut_if.state), 32'(e.state));
            check({tag, "_bus"}, 32'(dut_if.control_bus), 32'(e.bus));
            check({tag, "_retire"}, 32'(dut_if.retire), 32'(e.retire));
        end
        @(posedge clk);
        #1;
    endtask

    // Reference sequences, hand-encoded from the field layout.
    task automatic push_model(input logic [5:0] op, input logic [5:0] funct, input logic zero);
        logic [2:0] alu;
        exp_push(StFetch, 15'h180A, 1'b0);
        exp_push(StDecode, 15'h001A, 1'b0);
        case (op)
            6'b100011: begin
                exp_push(StMemAdr, 15'h0412, 1'b0);
                exp_push(StMemRd, 15'h4000, 1'b0);
                exp_push(StMemWb, 15'h0280, 1'b1);
            end
            6'b101011: begin
                exp_push(StMemAdr, 15'h0412, 1'b0);
                exp_push(StMemWr, 15'h6000, 1'b1);
            end
            6'b000000: begin
                case (funct)
                    6'b100010: alu = 3'b110;
                    6'b100100: alu = 3'b000;
                    6'b100101: alu = 3'b001;
                    6'b101010: alu = 3'b111;
                    default:   alu = 3'b010;
                endcase
                exp_push(StExecute, 15'h0400 | 15'(alu), 1'b0);
                exp_push(StAluWb, 15'h0300, 1'b1);
            end
            6'b000100: exp_push(StBranch, zero ? 15'h0C26 : 15'h0426, 1'b1);
            6'b001000: begin
                exp_push(StAddiExec, 15'h0412, 1'b0);
                exp_push(StAddiWb, 15'h0200, 1'b1);
            end
            6'b000010: exp_push(StJump, 15'h0840, 1'b1);
`ifdef MC_CTRL_BNE_EN
            6'b000101: exp_push(StBranch, zero ? 15'h0426 : 15'h0C26, 1'b1);
`endif
            default: ;
        endcase
    endtask

    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] funct,
                             input logic zero);
        int n;
        dut_if.op    = op;
        dut_if.funct = funct;
        dut_if.zero  = zero;
        push_model(op, funct, zero);
        n = sb.size();
        for (int i = 0; i < n; i++) cycle_check(tag);
    endtask

    initial begin
        reset        = 1'b1;
        dut_if.op    = 6'd0;
        dut_if.funct = 6'd0;
        dut_if.zero  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bus", 32'(dut_if.control_bus), 32'h0);
        check("rst_retire", 32'(dut_if.retire), 32'h0);
        check("rst_state", 32'(dut_if.state), 32'(StFetch));
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr("lw", 6'b100011, 6'd0, 1'b0);
        run_instr("sw", 6'b101011, 6'd0, 1'b0);
        run_instr("r_add", 6'b000000, 6'b100000, 1'b0);
        run_instr("r_sub", 6'b000000, 6'b100010, 1'b0);
        run_instr("r_and", 6'b000000, 6'b100100, 1'b0);
        run_instr("r_or", 6'b000000, 6'b100101, 1'b0);
        run_instr("r_slt", 6'b000000, 6'b101010, 1'b0);
        run_instr("r_unk", 6'b000000, 6'b111111, 1'b0);
        run_instr("addi", 6'b001000, 6'd0, 1'b0);
        run_instr("beq_z1", 6'b000100, 6'd0, 1'b1);
        run_instr("beq_z0", 6'b000100, 6'd0, 1'b0);
        run_instr("j", 6'b000010, 6'd0, 1'b0);
        run_instr("nop_op", 6'b111111, 6'd0, 1'b0);
        run_instr("bne_z0", 6'b000101, 6'd0, 1'b0);
        run_instr("bne_z1", 6'b000101, 6'd0, 1'b1);

        // Abandon a store: reset arrives while in MEMWR.
        dut_if.op = 6'b101011;
        exp_push(StFetch, 15'h180A, 1'b0);
        exp_push(StDecode, 15'h001A, 1'b0);
        exp_push(StMemAdr, 15'h0412, 1'b0);
        for (int i = 0; i < 3; i++) cycle_check("sw_abort");
        check("memwr_state", 32'(dut_if.state), 32'(StMemWr));
        check("memwr_bus", 32'(dut_if.control_bus), 32'h6000);
        reset = 1'b1;
        #1;
        check("memwr_rst_bus", 32'(dut_if.control_bus), 32'h0);
        check("memwr_rst_retire", 32'(dut_if.retire), 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_state", 32'(dut_if.state), 32'(StFetch));
        reset = 1'b0;
        #1;
        check("post_rst_bus", 32'(dut_if.control_bus), 32'h180A);
        @(posedge clk);
        #1;
        check("post_rst_decode", 32'(dut_if.state), 32'(StDecode));
        repeat (3) @(posedge clk);
        #1;
        // Back in FETCH after the store completes from its re-fetch.
        run_instr("lw2", 6'b100011, 6'd0, 1'b0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
